// File: rtl/averager_pkg.sv
// Shared constants and types for axis_decimating_averager and its per-channel accumulators.
package averager_pkg;
   localparam int unsigned MAX_LOG2     = 8;
   localparam int unsigned SAMPLE_WIDTH = 32;

   typedef logic signed [SAMPLE_WIDTH-1:0]          sample_t;
   typedef logic signed [SAMPLE_WIDTH+MAX_LOG2-1:0] acc_t;
   typedef logic        [MAX_LOG2:0]                count_t;
endpackage

// File: rtl/channel_accumulator.sv
// One channel's window sum, sample count and scaled (averaged) result.
// Define AVERAGER_ROUNDING_EN for round-half-up; otherwise the shift floors toward minus infinity.
module channel_accumulator
   import averager_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned LOG2       = 2
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         accept,
   input  logic signed [DATA_WIDTH-1:0] sample,
   output logic                         complete,
   output logic        [DATA_WIDTH-1:0] result
);
   localparam int unsigned ACC_W  = DATA_WIDTH + MAX_LOG2;
   localparam count_t      WINDOW = count_t'(1 << LOG2);
`ifdef AVERAGER_ROUNDING_EN
   // Half an LSB of the shifted result; collapses to zero for a window of one.
   localparam logic signed [ACC_W-1:0] OFFSET = ACC_W'((1 << LOG2) >> 1);
`else
   localparam logic signed [ACC_W-1:0] OFFSET = '0;
`endif

   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] sum;
   count_t                  cnt;

   assign sum      = acc + {{MAX_LOG2{sample[DATA_WIDTH-1]}}, sample};
   assign complete = accept && ((cnt + count_t'(1)) == WINDOW);
   assign result   = DATA_WIDTH'((sum + OFFSET) >>> LOG2);

   always_ff @(posedge clock) begin
      if (!reset) begin
         acc <= '0;
         cnt <= '0;
      end else if (complete) begin
         acc <= '0;
         cnt <= '0;
      end else if (accept) begin
         acc <= sum;
         cnt <= cnt + count_t'(1);
      end
   end
endmodule

// File: rtl/axis_decimating_averager.sv
// Per-channel decimating averager on a dest-tagged AXI-stream; one output per completed window.
// Rounding is selected in channel_accumulator by the AVERAGER_ROUNDING_EN macro.
module axis_decimating_averager
   import averager_pkg::*;
#(
   parameter int unsigned DATA_WIDTH                   = 32,
   parameter int unsigned N_CHANNELS                   = 2,
   parameter int unsigned DEST_WIDTH                   = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1,
   parameter int unsigned LOG2_WINDOW [N_CHANNELS-1:0] = '{3, 2}
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [DEST_WIDTH-1:0] in_dest,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [DEST_WIDTH-1:0] out_dest,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  dest_error
);
   localparam logic [DEST_WIDTH:0] DEST_LIMIT = (DEST_WIDTH+1)'(N_CHANNELS);

   logic                  accept;
   logic                  dest_ok;
   logic [N_CHANNELS-1:0] complete;
   logic [DATA_WIDTH-1:0] result [N_CHANNELS];
   logic                  any_complete;
   logic [DEST_WIDTH-1:0] sel_dest;
   logic [DATA_WIDTH-1:0] sel_data;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   assign dest_ok  = {1'b0, in_dest} < DEST_LIMIT;

   for (genvar g = 0; g < N_CHANNELS; g++) begin : g_chan
      channel_accumulator #(
         .DATA_WIDTH (DATA_WIDTH),
         .LOG2       (LOG2_WINDOW[g])
      ) u_acc (
         .clock    (clock),
         .reset    (reset),
         .accept   (accept && dest_ok && (in_dest == DEST_WIDTH'(g))),
         .sample   (in_data),
         .complete (complete[g]),
         .result   (result[g])
      );
   end

   // Only the addressed channel can complete in a cycle, so this is a plain one-hot select.
   always_comb begin
      sel_dest = '0;
      sel_data = '0;
      for (int unsigned i = 0; i < N_CHANNELS; i++) begin
         if (complete[i]) begin
            sel_dest = DEST_WIDTH'(i);
            sel_data = result[i];
         end
      end
   end

   assign any_complete = |complete;

   always_ff @(posedge clock) begin
      if (!reset) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_dest   <= '0;
         dest_error <= 1'b0;
      end else begin
         dest_error <= accept && !dest_ok;
         if (any_complete) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_dest  <= sel_dest;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_axis_decimating_averager.sv
// Bench for axis_decimating_averager: window-level reference model checked every cycle,
// plus literal expected outputs for each directed scenario.
module tb_axis_decimating_averager;
   logic        clock;
   logic        reset;
   logic [31:0] in_data;
   logic [1:0]  in_dest;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] out_data;
   logic [1:0]  out_dest;
   logic        out_valid;
   logic        out_ready;
   logic        dest_error;

   int checks = 0;
   int errors = 0;

   // dest is widened to 2 bits so that out-of-range channel 3 can be driven.
   axis_decimating_averager #(
      .DATA_WIDTH (32),
      .N_CHANNELS (2),
      .DEST_WIDTH (2)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .in_data    (in_data),
      .in_dest    (in_dest),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_data   (out_data),
      .out_dest   (out_dest),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .dest_error (dest_error)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

`ifdef AVERAGER_ROUNDING_EN
   localparam logic [31:0] RAMP_AVG = 32'd3;
`else
   localparam logic [31:0] RAMP_AVG = 32'd2;
`endif

   int          win_log2 [2] = '{2, 3};
   logic        m_valid = 1'b0;
   logic [31:0] m_data  = '0;
   logic [1:0]  m_dest  = '0;
   logic        m_err   = 1'b0;
   longint      hist [2][$];
   logic [31:0] cap_data [$];
   logic [1:0]  cap_dest [$];
   logic        mdl_take;
   int          mdl_ch;
   longint      mdl_sum;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Mean of a window as true division: floor, or round-half-up when rounding is built in.
   function automatic longint window_avg(input longint sum, input int l);
      longint w;
      longint s;
      longint q;
      w = longint'(1) << l;
      s = sum;
`ifdef AVERAGER_ROUNDING_EN
      if (l > 0) s = s + w / 2;
`endif
      q = s / w;
      if ((s % w != 0) && (s < 0)) q = q - 1;
      return q;
   endfunction

   // Reference model and per-cycle compare, evaluated on the falling edge.
   initial forever begin
      @(negedge clock);
      check("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
      check("in_ready", {63'd0, in_ready}, {63'd0, (!m_valid || out_ready)});
      check("dest_error", {63'd0, dest_error}, {63'd0, m_err});
      check("out_data", {32'd0, out_data}, {32'd0, m_data});
      check("out_dest", {62'd0, out_dest}, {62'd0, m_dest});
      if (reset && out_valid && out_ready) begin
         cap_data.push_back(out_data);
         cap_dest.push_back(out_dest);
      end
      if (!reset) begin
         m_valid = 1'b0;
         m_data  = '0;
         m_dest  = '0;
         m_err   = 1'b0;
         hist[0].delete();
         hist[1].delete();
      end else begin
         mdl_take = in_valid && (!m_valid || out_ready);
         if (m_valid && out_ready) m_valid = 1'b0;
         m_err = mdl_take && (in_dest >= 2'd2);
         if (mdl_take && (in_dest < 2'd2)) begin
            mdl_ch = int'(in_dest);
            hist[mdl_ch].push_back(longint'($signed(in_data)));
            if (hist[mdl_ch].size() == (1 << win_log2[mdl_ch])) begin
               mdl_sum = 0;
               for (int k = 0; k < hist[mdl_ch].size(); k++) mdl_sum += hist[mdl_ch][k];
               m_data  = 32'(window_avg(mdl_sum, win_log2[mdl_ch]));
               m_dest  = 2'(mdl_ch);
               m_valid = 1'b1;
               hist[mdl_ch].delete();
            end
         end
      end
   end

   task automatic send(input logic [1:0] d, input logic [31:0] x);
      int   n;
      logic took;
      n        = 0;
      took     = 1'b0;
      in_valid = 1'b1;
      in_dest  = d;
      in_data  = x;
      while (!took && n < 50) begin
         @(negedge clock);
         took = in_ready;
         @(posedge clock);
         #1;
         n++;
      end
      if (!took) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: got no in_ready expected acceptance of dest %0d at %0t", d, $time);
      end
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clock);
         #1;
      end
   endtask

   task automatic expect_out(input string name, input logic [31:0] d, input logic [1:0] ch);
      if (cap_data.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: got no output expected %0h on dest %0d", name, d, ch);
      end else begin
         check({name, "_data"}, {32'd0, cap_data.pop_front()}, {32'd0, d});
         check({name, "_dest"}, {62'd0, cap_dest.pop_front()}, {62'd0, ch});
      end
   endtask

   task automatic expect_none(input string name);
      check(name, 64'(cap_data.size()), 64'd0);
      cap_data.delete();
      cap_dest.delete();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b0;
      in_data   = '0;
      in_dest   = '0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      idle(3);
      reset = 1'b1;
      idle(1);

      // Ch0 ramp 1..4
      send(0, 32'd1); send(0, 32'd2); send(0, 32'd3); send(0, 32'd4);
      idle(3);
      expect_out("ramp", RAMP_AVG, 2'd0);
      expect_none("ramp_extra");

      // Ch1 constant -5, then seven -1 and one 0
      for (int i = 0; i < 8; i++) send(1, -32'sd5);
      idle(3);
      expect_out("neg5", -32'sd5, 2'd1);
      for (int i = 0; i < 7; i++) send(1, -32'sd1);
      send(1, 32'd0);
      idle(3);
      expect_out("neg_frac", -32'sd1, 2'd1);
      expect_none("neg_extra");

      // Alternating channels, all samples 10
      for (int i = 0; i < 8; i++) begin
         send(0, 32'd10);
         send(1, 32'd10);
      end
      idle(3);
      expect_out("ilv_a", 32'd10, 2'd0);
      expect_out("ilv_b", 32'd10, 2'd0);
      expect_out("ilv_c", 32'd10, 2'd1);
      expect_none("ilv_extra");

      // Full-scale extremes are exact
      for (int i = 0; i < 4; i++) send(0, 32'h8000_0000);
      idle(3);
      expect_out("full_neg", 32'h8000_0000, 2'd0);
      for (int i = 0; i < 4; i++) send(0, 32'h7FFF_FFFF);
      idle(3);
      expect_out("full_pos", 32'h7FFF_FFFF, 2'd0);
      expect_none("full_extra");

      // Backpressure with a ch1 completion waiting behind a stalled ch0 result
      for (int i = 0; i < 7; i++) send(1, 32'd2);
      for (int i = 0; i < 3; i++) send(0, 32'd6);
      out_ready = 1'b0;
      send(0, 32'd6);
      fork
         send(1, 32'd2);
         begin
            repeat (3) begin
               @(negedge clock);
               check("stall_in_ready", {63'd0, in_ready}, 64'd0);
               check("stall_out_data", {32'd0, out_data}, 64'd6);
            end
            @(posedge clock);
            #1;
            out_ready = 1'b1;
         end
      join
      idle(3);
      expect_out("stall_first", 32'd6, 2'd0);
      expect_out("stall_second", 32'd2, 2'd1);
      expect_none("stall_extra");

      // Out-of-range dest is dropped without touching ch0
      send(0, 32'd1); send(0, 32'd1);
      send(2'd3, 32'd100);
      check("dest_error_pulse", {63'd0, dest_error}, 64'd1);
      send(0, 32'd1);
      idle(2);
      expect_none("bad_dest_no_output");
      send(0, 32'd1);
      idle(3);
      expect_out("after_bad_dest", 32'd1, 2'd0);
      expect_none("bad_dest_extra");

      // Reset mid-window discards the partial sum
      for (int i = 0; i < 3; i++) send(0, 32'd5);
      reset = 1'b0;
      idle(1);
      reset = 1'b1;
      for (int i = 0; i < 4; i++) send(0, 32'd8);
      idle(3);
      expect_out("post_reset", 32'd8, 2'd0);
      expect_none("post_reset_extra");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
